// File: rtl/fastica_pkg.sv
// Shared constants, FSM state type and flat-bus slicing helper for the
// FastICA convergence checker.
package fastica_pkg;

  localparam int DATA_W = 26;
  localparam int N      = 4;
  localparam int NE     = N * N;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    FIN  = 2'd2
  } state_e;

  // LSB position of element k (k = 4*(r-1)+(c-1)) in a packed bus of w-bit elements.
  function automatic int elem_lsb(input int k, input int w);
    return w * k;
  endfunction

endpackage

// File: rtl/fastica_absdiff.sv
// Combinational |a-b| and |a+b| with one bit of headroom so neither result can
// overflow, even for full-scale opposite-sign inputs.
module fastica_absdiff #(
  parameter int DATA_W = 26
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic        [DATA_W:0]   diff_o,
  output logic        [DATA_W:0]   sum_o
);

  logic signed [DATA_W:0] a_ext;
  logic signed [DATA_W:0] b_ext;
  logic signed [DATA_W:0] d;
  logic signed [DATA_W:0] s;

  assign a_ext = {a_i[DATA_W-1], a_i};
  assign b_ext = {b_i[DATA_W-1], b_i};
  assign d     = a_ext - b_ext;
  assign s     = a_ext + b_ext;

  // Negating -2^DATA_W keeps the same bit pattern, which read unsigned is 2^DATA_W.
  assign diff_o = d[DATA_W] ? $unsigned(-d) : $unsigned(d);
  assign sum_o  = s[DATA_W] ? $unsigned(-s) : $unsigned(s);

endmodule

// File: rtl/fastica_conv_check.sv
// Serial sign-agnostic convergence check of the 4x4 FastICA weight matrix:
// one element per cycle, deviation = min(max|new-old|, max|new+old|).
module fastica_conv_check #(
  parameter int          DATA_W   = 26,
  parameter int unsigned TOL      = 16,
  parameter int          ITER_W   = 8,
  parameter int          MAX_ITER = 200
) (
  input  logic                             clk_conv,
  input  logic                             rst_conv,
  input  logic                             start_conv,
  input  logic                             clear_conv,
  input  logic [fastica_pkg::NE*DATA_W-1:0] w_flat,
  output logic                             busy_conv,
  output logic                             done_conv,
  output logic                             converged,
  output logic                             timeout,
  output logic [DATA_W:0]                  max_diff,
  output logic [ITER_W-1:0]                iter_cnt,
  output logic [1:0]                       state_dbg_o
);

  import fastica_pkg::*;

  localparam int FW = NE * DATA_W;

  state_e state_q, state_d;

  logic [3:0]              idx_q;
  logic [FW-1:0]           snap_q;
  logic [FW-1:0]           old_q;
  logic [DATA_W:0]         maxd_q;
  logic [DATA_W:0]         maxs_q;
  logic [DATA_W:0]         max_diff_q;
  logic                    first_valid_q;
  logic                    conv_q;
  logic                    timeout_q;
  logic                    done_q;
  logic [ITER_W-1:0]       iter_q;

  logic signed [DATA_W-1:0] new_e;
  logic signed [DATA_W-1:0] old_e;
  logic [DATA_W:0]          d_e;
  logic [DATA_W:0]          s_e;
  logic [DATA_W:0]          min_ds;
  logic                     conv_next;
  logic [ITER_W:0]          iter_inc;

  // Before any history exists the reference W is treated as all zeros.
  assign new_e = snap_q[elem_lsb(int'(idx_q), DATA_W) +: DATA_W];
  assign old_e = first_valid_q ? old_q[elem_lsb(int'(idx_q), DATA_W) +: DATA_W] : '0;

  fastica_absdiff #(.DATA_W(DATA_W)) u_absdiff (
    .a_i    (new_e),
    .b_i    (old_e),
    .diff_o (d_e),
    .sum_o  (s_e)
  );

  assign min_ds    = (maxd_q < maxs_q) ? maxd_q : maxs_q;
  assign conv_next = first_valid_q && (min_ds <= (DATA_W+1)'(TOL));
  assign iter_inc  = {1'b0, iter_q} + (ITER_W+1)'(1);

  always_ff @(posedge clk_conv or posedge rst_conv) begin
    if (rst_conv) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_conv && !clear_conv) state_d = SCAN;
      SCAN:    if (idx_q == 4'(NE-1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_conv or posedge rst_conv) begin
    if (rst_conv) begin
      idx_q         <= '0;
      snap_q        <= '0;
      old_q         <= '0;
      maxd_q        <= '0;
      maxs_q        <= '0;
      max_diff_q    <= '0;
      first_valid_q <= 1'b0;
      conv_q        <= 1'b0;
      timeout_q     <= 1'b0;
      done_q        <= 1'b0;
      iter_q        <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clear_conv) begin
            iter_q        <= '0;
            first_valid_q <= 1'b0;
            conv_q        <= 1'b0;
            timeout_q     <= 1'b0;
          end else if (start_conv) begin
            snap_q <= w_flat;
            idx_q  <= '0;
            maxd_q <= '0;
            maxs_q <= '0;
          end
        end
        SCAN: begin
          maxd_q <= (d_e > maxd_q) ? d_e : maxd_q;
          maxs_q <= (s_e > maxs_q) ? s_e : maxs_q;
          idx_q  <= idx_q + 4'd1;
        end
        FIN: begin
          max_diff_q    <= min_ds;
          conv_q        <= conv_next;
          old_q         <= snap_q;
          first_valid_q <= 1'b1;
          iter_q        <= (&iter_q) ? iter_q : iter_inc[ITER_W-1:0];
          // Timeout uses the unsaturated count so it stays asserted once reached.
          timeout_q     <= !conv_next && (iter_inc >= (ITER_W+1)'(MAX_ITER));
          done_q        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy_conv   = (state_q != IDLE);
  assign done_conv   = done_q;
  assign converged   = conv_q;
  assign timeout     = timeout_q;
  assign max_diff    = max_diff_q;
  assign iter_cnt    = iter_q;
  assign state_dbg_o = state_q;

endmodule

// File: tb/tb_fastica_conv_check.sv
// Randomized and directed bench for fastica_conv_check with a reference model
// and an expected-result queue checked by a done-driven monitor.
module tb_fastica_conv_check;

  localparam int     DW     = 26;
  localparam int     MAXI   = 3;
  localparam longint TOL_TB = 16;
  localparam longint WMAX   = 33554431;
  localparam longint WMIN   = -33554432;

  // clock/reset
  logic            clk_conv = 1'b0;
  logic            rst_conv;
  logic            start_conv;
  logic            clear_conv;
  logic [16*DW-1:0] w_flat;
  logic            busy_conv, done_conv, converged, timeout;
  logic [DW:0]     max_diff;
  logic [7:0]      iter_cnt;
  logic [1:0]      state_dbg;

  always #5 clk_conv = ~clk_conv;

  fastica_conv_check #(.DATA_W(DW), .TOL(16), .ITER_W(8), .MAX_ITER(MAXI)) dut (
    .clk_conv    (clk_conv),
    .rst_conv    (rst_conv),
    .start_conv  (start_conv),
    .clear_conv  (clear_conv),
    .w_flat      (w_flat),
    .busy_conv   (busy_conv),
    .done_conv   (done_conv),
    .converged   (converged),
    .timeout     (timeout),
    .max_diff    (max_diff),
    .iter_cnt    (iter_cnt),
    .state_dbg_o (state_dbg)
  );

  int n_assert = 0;
  int n_fail   = 0;
  logic [36:0] exp_q[$];
  logic [36:0] mon_e;

  // reference model state
  longint w_vec[16];
  longint m_old[16];
  bit     m_fv;
  int     m_iter;
  bit     m_conv, m_to;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint labs(input longint x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic longint clamp(input longint x);
    if (x > WMAX) return WMAX;
    if (x < WMIN) return WMIN;
    return x;
  endfunction

  task automatic model_push();
    longint dm, sm, o, mn;
    bit cv, to;
    dm = 0; sm = 0;
    for (int k = 0; k < 16; k++) begin
      o = m_fv ? m_old[k] : 0;
      if (labs(w_vec[k] - o) > dm) dm = labs(w_vec[k] - o);
      if (labs(w_vec[k] + o) > sm) sm = labs(w_vec[k] + o);
    end
    mn = (dm < sm) ? dm : sm;
    cv = m_fv && (mn <= TOL_TB);
    to = !cv && (m_iter + 1 >= MAXI);
    m_iter = (m_iter == 255) ? 255 : m_iter + 1;
    m_old  = w_vec;
    m_fv   = 1'b1;
    m_conv = cv;
    m_to   = to;
    exp_q.push_back({mn[26:0], cv, to, m_iter[7:0]});
  endtask

  task automatic model_clear();
    m_fv = 1'b0; m_iter = 0; m_conv = 1'b0; m_to = 1'b0;
  endtask

  // driver tasks
  task automatic drive_w();
    for (int k = 0; k < 16; k++) w_flat[k*DW +: DW] = DW'(w_vec[k]);
  endtask

  task automatic set_all(input longint v);
    for (int k = 0; k < 16; k++) w_vec[k] = v;
  endtask

  task automatic run_check(input bit extra);
    int cyc, busy_n;
    bit seen;
    @(negedge clk_conv);
    drive_w();
    start_conv = 1'b1;
    model_push();
    cyc = 0; busy_n = 0; seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(negedge clk_conv);
      cyc++;
      if (cyc == 1) start_conv = 1'b0;
      if (extra && cyc == 5) begin
        w_flat = ~w_flat; start_conv = 1'b1; clear_conv = 1'b1;
      end
      if (extra && cyc == 6) begin
        start_conv = 1'b0; clear_conv = 1'b0;
      end
      if (busy_conv) busy_n++;
      seen = done_conv;
    end
    if (!seen) begin
      n_assert++; n_fail++;
      $display("FAIL done_wait: no done within %0d cycles", cyc);
    end else begin
      chk("latency", 64'(cyc - 1), 64'd17);
      chk("busy_cycles", 64'(busy_n), 64'd17);
    end
  endtask

  task automatic clear_idle();
    @(negedge clk_conv);
    clear_conv = 1'b1; start_conv = 1'b1; w_flat = {16{26'd5}};
    @(negedge clk_conv);
    clear_conv = 1'b0; start_conv = 1'b0;
    model_clear();
    chk("clr_iter_cnt", iter_cnt, 64'(m_iter));
    chk("clr_converged", converged, 64'(m_conv));
    chk("clr_timeout", timeout, 64'(m_to));
    repeat (3) @(negedge clk_conv);
    chk("clr_no_scan_busy", busy_conv, 64'd0);
  endtask

  task automatic reset_mid_scan();
    set_all(77);
    @(negedge clk_conv);
    drive_w(); start_conv = 1'b1;
    @(negedge clk_conv);
    start_conv = 1'b0;
    repeat (7) @(negedge clk_conv);
    #2 rst_conv = 1'b1;
    #1;
    chk("rst_busy", busy_conv, 64'd0);
    chk("rst_done", done_conv, 64'd0);
    chk("rst_converged", converged, 64'd0);
    chk("rst_timeout", timeout, 64'd0);
    chk("rst_max_diff", max_diff, 64'd0);
    chk("rst_iter_cnt", iter_cnt, 64'd0);
    model_clear();
    for (int k = 0; k < 16; k++) m_old[k] = 0;
    @(negedge clk_conv);
    @(negedge clk_conv);
    rst_conv = 1'b0;
    repeat (20) @(negedge clk_conv);
  endtask

  // scoreboard monitor
  always @(negedge clk_conv) begin
    if (!rst_conv && done_conv) begin
      if (exp_q.size() == 0) begin
        n_assert++; n_fail++;
        $display("FAIL unexpected_done: done pulse with no pending check at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        chk("max_diff", max_diff, 64'(mon_e[36:10]));
        chk("converged", converged, 64'(mon_e[9]));
        chk("timeout", timeout, 64'(mon_e[8]));
        chk("iter_cnt", iter_cnt, 64'(mon_e[7:0]));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mode;
    logic signed [DW-1:0] r;
    rst_conv = 1'b1; start_conv = 1'b0; clear_conv = 1'b0; w_flat = '0;
    model_clear();
    for (int k = 0; k < 16; k++) m_old[k] = 0;
    #1;
    chk("init_busy", busy_conv, 64'd0);
    chk("init_done", done_conv, 64'd0);
    chk("init_converged", converged, 64'd0);
    chk("init_max_diff", max_diff, 64'd0);
    chk("init_iter_cnt", iter_cnt, 64'd0);
    repeat (2) @(negedge clk_conv);
    rst_conv = 1'b0;

    // first check, identical repeat, sign flip
    set_all(100);  run_check(1'b0);
    set_all(100);  run_check(1'b0);
    set_all(-100); run_check(1'b0);
    // tolerance boundary on w23
    set_all(100);  run_check(1'b0);
    w_vec[6] = 117; run_check(1'b0);
    run_check(1'b0);
    set_all(100);  run_check(1'b0);
    w_vec[6] = 116; run_check(1'b0);
    // full-scale extremes
    set_all(WMAX); run_check(1'b0);
    w_vec[0] = WMIN; run_check(1'b0);
    // start/clear while busy are ignored
    set_all(-5);   run_check(1'b1);
    clear_idle();
    reset_mid_scan();
    set_all(100);  run_check(1'b0);

    // timeout with alternating W
    clear_idle();
    set_all(100); run_check(1'b0);
    set_all(300); run_check(1'b0);
    set_all(100); run_check(1'b0);
    clear_idle();

    for (int i = 0; i < 30; i++) begin
      mode = $urandom_range(0, 3);
      for (int k = 0; k < 16; k++) begin
        case (mode)
          0: begin r = DW'($urandom); w_vec[k] = r; end
          1: w_vec[k] = clamp(m_old[k] + longint'($urandom_range(0, 40)) - 20);
          2: w_vec[k] = clamp(-m_old[k] + longint'($urandom_range(0, 40)) - 20);
          default: w_vec[k] = longint'($urandom_range(0, 100)) - 50;
        endcase
      end
      run_check($urandom_range(0, 3) == 0);
      if (i % 10 == 9) clear_idle();
    end

    repeat (5) @(negedge clk_conv);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fastica_conv_check.md
Name: fastica_conv_check

Overview:
- Sits directly downstream of the 4x4 weight subtractor in the one-unit FastICA datapath and consumes its 16 signed 26-bit outputs W.
- Compares each new W against the W from the previous iteration and accepts either sign, since FastICA treats W and -W as the same solution.
- Reports per-iteration max deviation, a converged flag, an iteration count and a timeout to the iteration controller.
- Elements are processed serially, one per cycle, through a single abs-difference unit.

Parameters:
- DATA_W, 26: element width (signed two's complement).
- TOL, 16: convergence tolerance (unsigned, DATA_W+1 bits); deviation <= TOL counts as converged.
- ITER_W, 8: iteration counter width.
- MAX_ITER, 200: iteration count at which timeout asserts.

Ports:
- clk_conv  in  1  rising-edge clock.
- rst_conv  in  1  asynchronous, active-high reset.
- start_conv  in  1  one-cycle pulse: w_flat holds a valid new W (subtractor output).
- clear_conv  in  1  synchronous; clears iteration history.
- w_flat  in  16*DATA_W  packed W. Element (r,c) sits at [DATA_W*k +: DATA_W] with k=4*(r-1)+(c-1), so w11 is at LSBs and w44 at MSBs.
- busy_conv  out  1  high while not IDLE.
- done_conv  out  1  one-cycle pulse when a check completes.
- converged  out  1  result of last check.
- timeout  out  1  MAX_ITER reached without convergence.
- max_diff  out  DATA_W+1  deviation of last check (unsigned).
- iter_cnt  out  ITER_W  completed checks since reset/clear (saturating).

Behaviour:
- Reset (async, rst_conv=1):
  - state=IDLE; all outputs 0.
  - Old-W store, snapshot, index and accumulators 0.
  - first_valid=0.
  - Reset mid-scan aborts the scan with no done pulse.
- States IDLE, SCAN, FIN.
- IDLE:
  - clear_conv=1 sets iter_cnt=0, first_valid=0, converged=0, timeout=0. Clear wins over a simultaneous start, which is dropped.
  - Otherwise start_conv=1 at edge T does all of the following: snapshot<=w_flat, idx<=0, maxd<=0, maxs<=0, state->SCAN.
- SCAN (edges T+1..T+16), for element k=idx:
  - d = |new_k - old_k| and s = |new_k + old_k|, computed in DATA_W+1-bit signed, then abs. The result is always representable; no saturation.
  - maxd <= max(maxd,d); maxs <= max(maxs,s).
  - idx++ each cycle.
  - At idx=15 the accumulator update completes and state->FIN (edge T+16).
- FIN (edge T+17):
  - max_diff <= min(maxd,maxs).
  - converged <= first_valid && min(maxd,maxs) <= TOL.
  - old-W store <= snapshot; first_valid <= 1.
  - iter_cnt <= iter_cnt+1, saturating at all-ones.
  - timeout <= !converged_next && (iter_cnt+1 >= MAX_ITER).
  - done_conv <= 1 for exactly one cycle; state->IDLE.
- Latency: start at edge T gives done_conv high in the cycle after edge T+17. busy_conv is high after edge T through edge T+17.
- start_conv and clear_conv while busy are ignored; they are not queued.
- w_flat is sampled only at the start edge, so the upstream block may change it afterwards.
- Results hold until the next FIN, clear, or reset.
- The first check after reset/clear compares against an all-zero old W, so d = s = |new|. converged is forced to 0 on that check.

Decomposition:
- Shared package fastica_pkg: DATA_W, N=4, NE=16, the state enum (IDLE/SCAN/FIN), and an element-index helper for the flat-bus slicing.
- One sub-module, fastica_absdiff: combinational; inputs a, b (DATA_W signed); outputs |a-b| and |a+b| (DATA_W+1 unsigned).
- The FSM, storage and accumulators stay in the top.

Test Plan:
- Reset check: assert rst_conv asynchronously mid-cycle -> all outputs 0 immediately; busy_conv=0.
- First check: all 16 elements = 100, start pulse -> done_conv exactly 17 cycles later; max_diff=100; converged=0; iter_cnt=1; busy high for 17 cycles.
- Converge check: repeat with identical W -> max_diff=0, converged=1, iter_cnt=2. Then repeat with all elements = -100 (sign flip) -> maxd=200, maxs=0, max_diff=0, converged=1, iter_cnt=3.
- Tolerance boundary (TOL=16), old W all 100:
  - w23=117 -> max_diff=17, converged=0.
  - Next check with the same value -> max_diff=0, converged=1.
  - A separate run with w23=116 vs old 100 -> max_diff=16, converged=1.
  - Extremes: w11=-2^25 vs old 2^25-1 -> d=2^26-1, with no overflow.
- Protocol checks:
  - Second start during SCAN is ignored; only one done pulse occurs.
  - clear_conv with start in IDLE -> no scan; iter_cnt=0.
  - rst_conv at scan cycle 8 -> no done pulse; the next check behaves as a first check.
- Timeout: MAX_ITER=3, feed alternating W of +100 and +300 -> timeout=1 on the 3rd done pulse with converged=0. clear_conv clears timeout.
